// File: rtl/qsincos_pkg.sv
// qsincos_pkg: shared CORDIC constants, arctangent table and FSM state type for qsincos
package qsincos_pkg;
    localparam int QUAD_ONE = 'h324;
    localparam int QUAD_TWO = 'h648;
    localparam int PI_Q     = 'hC91;
    localparam int CORDIC_K = 'h26E;
    localparam int ATAN_TABLE [16] = '{804, 475, 251, 127, 64, 32, 16, 8, 4, 2, 1, 0, 0, 0, 0, 0};
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
endpackage

// File: rtl/qsincos_stage.sv
// qsincos_stage: one combinational CORDIC rotation step; QSINCOS_ROUND_EN selects round-half-up shifts
module qsincos_stage
    import qsincos_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic signed [DATA_WIDTH-1:0] y,
    input  logic signed [DATA_WIDTH-1:0] z,
    input  logic        [3:0]            idx,
    input  logic signed [DATA_WIDTH-1:0] atan,
    output logic signed [DATA_WIDTH-1:0] x_n,
    output logic signed [DATA_WIDTH-1:0] y_n,
    output logic signed [DATA_WIDTH-1:0] z_n
);
    function automatic logic signed [DATA_WIDTH-1:0] sh(input logic signed [DATA_WIDTH-1:0] v,
                                                        input logic [3:0] i);
`ifdef QSINCOS_ROUND_EN
        logic signed [DATA_WIDTH-1:0] half;
        half = (i == 4'd0) ? '0 : (DATA_WIDTH'(1) <<< (i - 4'd1));
        return (v + half) >>> i;
`else
        return v >>> i;
`endif
    endfunction

    logic d;

    always_comb begin
        d   = ~z[DATA_WIDTH-1];
        x_n = d ? x - sh(y, idx) : x + sh(y, idx);
        y_n = d ? y + sh(x, idx) : y - sh(x, idx);
        z_n = d ? z - atan : z + atan;
    end
endmodule

// File: rtl/qsincos.sv
// qsincos: iterative Q10 CORDIC phase-to-cos/sin converter with quadrant fold; macro QSINCOS_ROUND_EN
module qsincos
    import qsincos_pkg::*;
#(
    parameter int ITERATIONS = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] angle,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] cos_out,
    output logic signed [DATA_WIDTH-1:0] sin_out
);
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic neg_q, neg_d;
    logic signed [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d, cos_q, cos_d, sin_q, sin_d;
    logic signed [DATA_WIDTH-1:0] x_n, y_n, z_n;

    qsincos_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
        .x    (x_q),
        .y    (y_q),
        .z    (z_q),
        .idx  (cnt_q),
        .atan (DATA_WIDTH'(ATAN_TABLE[cnt_q])),
        .x_n  (x_n),
        .y_n  (y_n),
        .z_n  (z_n)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                // Fold angles beyond +-pi/2 by pi and negate the result instead
                neg_d   = (angle > DATA_WIDTH'(QUAD_TWO)) || (angle < -DATA_WIDTH'(QUAD_TWO));
                z_d     = (angle > DATA_WIDTH'(QUAD_TWO))  ? angle - DATA_WIDTH'(PI_Q) :
                          (angle < -DATA_WIDTH'(QUAD_TWO)) ? angle + DATA_WIDTH'(PI_Q) : angle;
                x_d     = DATA_WIDTH'(CORDIC_K);
                y_d     = '0;
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                x_d   = x_n;
                y_d   = y_n;
                z_d   = z_n;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(ITERATIONS - 1)) begin
                    cos_d   = neg_q ? -x_n : x_n;
                    sin_d   = neg_q ? -y_n : y_n;
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign cos_out   = cos_q;
    assign sin_out   = sin_q;
endmodule

// File: tb/tb_qsincos.sv
// tb_qsincos: directed-vector and sweep bench for qsincos against an independent CORDIC model
module tb_qsincos;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [31:0] angle = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [31:0] cos_out;
    logic signed [31:0] sin_out;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    qsincos dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .angle     (angle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_out   (cos_out),
        .sin_out   (sin_out)
    );

    typedef struct {
        int ang;
        int c;
        int s;
    } vec_t;

    task automatic chk(input string name, input bit ok, input int act, input int exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    function automatic int shr(input int v, input int i);
`ifdef QSINCOS_ROUND_EN
        return i == 0 ? v : (v + (1 << (i - 1))) >>> i;
`else
        return v >>> i;
`endif
    endfunction

    function automatic void model(input int a, output int c, output int s);
        int atan_t [16] = '{804, 475, 251, 127, 64, 32, 16, 8, 4, 2, 1, 0, 0, 0, 0, 0};
        int x = 622, y = 0, z = a, tx, sgn = 1;
        if (a > 1608) begin z = a - 3217; sgn = -1; end
        else if (a < -1608) begin z = a + 3217; sgn = -1; end
        for (int i = 0; i < 10; i++) begin
            tx = x;
            if (z >= 0) begin x = x - shr(y, i); y = y + shr(tx, i); z = z - atan_t[i]; end
            else begin x = x + shr(y, i); y = y - shr(tx, i); z = z + atan_t[i]; end
        end
        c = sgn * x;
        s = sgn * y;
    endfunction

    task automatic run(input int a, output int c, output int s, output int lat);
        int w = 0;
        while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
        angle = a;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        c = cos_out;
        s = sin_out;
        if (out_ready) begin @(posedge clk); #1; end
    endtask

    initial begin
        vec_t vecs [6];
        int c, s, lat, mc, ms, c0, s0, extra;
        vecs = '{'{0, 1024, 0}, '{'h324, 724, 724}, '{'h648, 0, 1024},
                 '{-'h648, 0, -1024}, '{-'hC91, -1024, 0}, '{'h96C, -724, 724}};
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("reset_cos", cos_out == 0, cos_out, 0);
        chk("reset_sin", sin_out == 0, sin_out, 0);
        chk("reset_out_valid", out_valid == 1'b0, int'(out_valid), 0);
        chk("reset_in_ready", in_ready == 1'b1, int'(in_ready), 1);

        foreach (vecs[k]) begin
            run(vecs[k].ang, c, s, lat);
            model(vecs[k].ang, mc, ms);
            chk($sformatf("lat_%0d", vecs[k].ang), lat == 10, lat, 10);
            chk($sformatf("cos_%0d", vecs[k].ang), iabs(c - vecs[k].c) <= 4, c, vecs[k].c);
            chk($sformatf("sin_%0d", vecs[k].ang), iabs(s - vecs[k].s) <= 4, s, vecs[k].s);
            chk($sformatf("exact_cos_%0d", vecs[k].ang), c == mc, c, mc);
            chk($sformatf("exact_sin_%0d", vecs[k].ang), s == ms, s, ms);
        end

        out_ready = 1'b0;
        run('h324, c0, s0, lat);
        chk("stall_lat", lat == 10, lat, 10);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            angle = 0;
            @(posedge clk); #1;
            chk("stall_valid", out_valid == 1'b1, int'(out_valid), 1);
            chk("stall_cos", cos_out == c0, cos_out, c0);
            chk("stall_sin", sin_out == s0, sin_out, s0);
            chk("stall_in_ready", in_ready == 1'b0, int'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", out_valid == 1'b0, int'(out_valid), 0);
        chk("release_in_ready", in_ready == 1'b1, int'(in_ready), 1);
        chk("release_cos_kept", cos_out == c0, cos_out, c0);
        extra = 0;
        for (int i = 0; i < 15; i++) begin @(posedge clk); #1; extra += int'(out_valid); end
        chk("stall_no_extra", extra == 0, extra, 0);

        angle = 'h324;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_cos", cos_out == 0, cos_out, 0);
        chk("abort_sin", sin_out == 0, sin_out, 0);
        chk("abort_valid", out_valid == 1'b0, int'(out_valid), 0);
        chk("abort_in_ready", in_ready == 1'b1, int'(in_ready), 1);
        reset = 1'b1;
        extra = 0;
        for (int i = 0; i < 15; i++) begin @(posedge clk); #1; extra += int'(out_valid); end
        chk("abort_no_result", extra == 0, extra, 0);
        run(0, c, s, lat);
        chk("post_abort_lat", lat == 10, lat, 10);
        chk("post_abort_cos", iabs(c - 1024) <= 4, c, 1024);
        chk("post_abort_sin", iabs(s) <= 4, s, 0);

        for (int i = 0; i < 1000; i++) begin
            int a;
            a = int'($urandom_range(0, 6434)) - 3217;
            run(a, c, s, lat);
            model(a, mc, ms);
            chk($sformatf("sweep_%0d", a), lat == 10 && c == mc && s == ms, c, mc);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
